// File: rtl/icache.sv
// 2-way set-associative instruction cache: 128 sets of 32 B lines, one LRU bit per set,
// single outstanding request. Define ICACHE_DEBUG_PORTS_EN to expose the debug outputs.
module icache (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_Itlb_drive,
  input  logic [33:0]  i_Itlb_PA_34,
  input  logic         i_L2Cache_drive,
  input  logic         i_freeNext_L2Cache,
  input  logic [255:0] i_L2Cache_refillLine_32B,
  input  logic         i_freeNext_ifu,
  output logic         o_Itlb_free,
  output logic         o_L2Cache_free,
  output logic         o_driveNext_L2Cache,
  output logic [33:0]  o_miss_Addr_to_L2cache_34,
  output logic         o_driveNext_ifu,
  output logic [255:0] o_hit_data_to_ifu_32B
`ifdef ICACHE_DEBUG_PORTS_EN
  ,
  output logic         o_write_enable,
  output logic [1:0]   o_fifo_buffer_write_enable_2,
  output logic [33:0]  o_fifo2_1_addr_34,
  output logic         o_fifo_buffer_data_out
`endif
);

  localparam int SETS  = 128;
  localparam int TAG_W = 22;

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, WAIT_REFILL, RESP} state_t;

  state_t state;

  // Line address of the accepted request: {tag[21:0], index[6:0]}.
  logic [28:0]       line_q;
  logic [TAG_W-1:0]  tag;
  logic [6:0]        idx;

  logic [TAG_W-1:0]  tag_mem  [2][SETS];
  logic [255:0]      data_mem [2][SETS];
  logic [SETS-1:0]   valid_q  [2];
  logic [SETS-1:0]   lru_q;

  logic              hit0, hit1, hit_any;
  logic              victim;
  logic              refill_we;
  logic [255:0]      hit_line;

  assign tag = line_q[28:7];
  assign idx = line_q[6:0];

  assign hit0     = valid_q[0][idx] && (tag_mem[1'b0][idx] == tag);
  assign hit1     = valid_q[1][idx] && (tag_mem[1'b1][idx] == tag);
  assign hit_any  = hit0 | hit1;
  assign hit_line = hit1 ? data_mem[1'b1][idx] : data_mem[1'b0][idx];

  // lru_q points at the least-recently-used way, which is the victim once both ways are valid.
  assign victim    = !valid_q[0][idx] ? 1'b0 :
                     !valid_q[1][idx] ? 1'b1 : lru_q[idx];
  assign refill_we = (state == WAIT_REFILL) && i_L2Cache_drive;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state                     <= IDLE;
      line_q                    <= '0;
      valid_q                   <= '{default: '0};
      lru_q                     <= '0;
      o_Itlb_free               <= 1'b1;
      o_L2Cache_free            <= 1'b0;
      o_driveNext_L2Cache       <= 1'b0;
      o_miss_Addr_to_L2cache_34 <= '0;
      o_driveNext_ifu           <= 1'b0;
      o_hit_data_to_ifu_32B     <= '0;
    end else begin
      o_driveNext_L2Cache <= 1'b0;
      o_driveNext_ifu     <= 1'b0;
      case (state)
        IDLE: begin
          if (i_Itlb_drive) begin
            line_q      <= i_Itlb_PA_34[33:5];
            o_Itlb_free <= 1'b0;
            state       <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit_any) begin
            lru_q[idx]            <= ~hit1;
            o_hit_data_to_ifu_32B <= hit_line;
            o_driveNext_ifu       <= 1'b1;
            state                 <= RESP;
          end else begin
            o_miss_Addr_to_L2cache_34 <= {line_q, 5'b0};
            o_driveNext_L2Cache       <= 1'b1;
            state                     <= MISS_REQ;
          end
        end
        MISS_REQ: begin
          if (i_freeNext_L2Cache) begin
            o_L2Cache_free <= 1'b1;
            state          <= WAIT_REFILL;
          end
        end
        WAIT_REFILL: begin
          if (i_L2Cache_drive) begin
            valid_q[victim][idx]  <= 1'b1;
            lru_q[idx]            <= ~victim;
            o_hit_data_to_ifu_32B <= i_L2Cache_refillLine_32B;
            o_driveNext_ifu       <= 1'b1;
            o_L2Cache_free        <= 1'b0;
            state                 <= RESP;
          end
        end
        RESP: begin
          if (i_freeNext_ifu) begin
            o_Itlb_free <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: tag and data arrays are deliberately not reset; the valid bits alone
  // make their contents meaningful, so they can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (refill_we) begin
      tag_mem[victim][idx]  <= tag;
      data_mem[victim][idx] <= i_L2Cache_refillLine_32B;
    end
  end

`ifdef ICACHE_DEBUG_PORTS_EN
  logic [33:0] pa_q;
  logic        last_hit_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pa_q       <= '0;
      last_hit_q <= 1'b0;
    end else begin
      if (state == IDLE && i_Itlb_drive) pa_q <= i_Itlb_PA_34;
      if (state == LOOKUP) last_hit_q <= hit_any;
    end
  end

  assign o_write_enable               = refill_we;
  assign o_fifo_buffer_write_enable_2 = refill_we ? (victim ? 2'b10 : 2'b01) : 2'b00;
  assign o_fifo2_1_addr_34            = pa_q;
  assign o_fifo_buffer_data_out       = last_hit_q;
`else
  // The line offset selects nothing inside a 32 B line fetch.
  logic unused_offset;
  assign unused_offset = ^i_Itlb_PA_34[4:0];
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed table, hand-written corner sequences and
// randomized traffic checked against a recency-ordered per-set reference model.
module tb_icache;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         i_Itlb_drive = 1'b0;
  logic [33:0]  i_Itlb_PA_34 = '0;
  logic         i_L2Cache_drive = 1'b0;
  logic         i_freeNext_L2Cache = 1'b0;
  logic [255:0] i_L2Cache_refillLine_32B = '0;
  logic         i_freeNext_ifu = 1'b0;
  logic         o_Itlb_free;
  logic         o_L2Cache_free;
  logic         o_driveNext_L2Cache;
  logic [33:0]  o_miss_Addr_to_L2cache_34;
  logic         o_driveNext_ifu;
  logic [255:0] o_hit_data_to_ifu_32B;

  icache dut (
    .clk                      (clk),
    .rstn                     (rstn),
    .i_Itlb_drive             (i_Itlb_drive),
    .i_Itlb_PA_34             (i_Itlb_PA_34),
    .i_L2Cache_drive          (i_L2Cache_drive),
    .i_freeNext_L2Cache       (i_freeNext_L2Cache),
    .i_L2Cache_refillLine_32B (i_L2Cache_refillLine_32B),
    .i_freeNext_ifu           (i_freeNext_ifu),
    .o_Itlb_free              (o_Itlb_free),
    .o_L2Cache_free           (o_L2Cache_free),
    .o_driveNext_L2Cache      (o_driveNext_L2Cache),
    .o_miss_Addr_to_L2cache_34(o_miss_Addr_to_L2cache_34),
    .o_driveNext_ifu          (o_driveNext_ifu),
    .o_hit_data_to_ifu_32B    (o_hit_data_to_ifu_32B)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model: each set is a list of resident lines, least recent first.
  typedef struct packed {
    logic [21:0]  tag;
    logic [255:0] data;
  } mline_t;

  mline_t set_q [128][$];

  task automatic model_clear();
    for (int s = 0; s < 128; s++) set_q[s].delete();
  endtask

  task automatic model_access(input logic [33:0] pa, input logic [255:0] refill,
                              output logic hit, output logic [255:0] data);
    int     s;
    int     pos;
    mline_t e;
    s   = int'(pa[11:5]);
    pos = -1;
    for (int i = 0; i < set_q[s].size(); i++)
      if (set_q[s][i].tag == pa[33:12]) pos = i;
    if (pos >= 0) begin
      hit  = 1'b1;
      e    = set_q[s][pos];
      data = e.data;
      set_q[s].delete(pos);
      set_q[s].push_back(e);
    end else begin
      hit    = 1'b0;
      data   = refill;
      e.tag  = pa[33:12];
      e.data = refill;
      if (set_q[s].size() == 2) set_q[s].delete(0);
      set_q[s].push_back(e);
    end
  endtask

  task automatic do_reset(input string name);
    rstn = 1'b0;
    #3;
    check({name, ".itlb_free"},    256'(o_Itlb_free), 256'(1));
    check({name, ".l2_free"},      256'(o_L2Cache_free), 256'(0));
    check({name, ".drive_l2"},     256'(o_driveNext_L2Cache), 256'(0));
    check({name, ".miss_addr"},    256'(o_miss_Addr_to_L2cache_34), 256'(0));
    check({name, ".drive_ifu"},    256'(o_driveNext_ifu), 256'(0));
    check({name, ".data"},         o_hit_data_to_ifu_32B, 256'(0));
    @(negedge clk);
    rstn = 1'b1;
    model_clear();
  endtask

  // Runs one complete request starting and ending at a falling edge in IDLE.
  task automatic run_req(input string name, input logic [33:0] pa, input logic [255:0] refill,
                         input logic exp_hit, input logic [255:0] exp_data);
    int d;
    check({name, ".idle_free"}, 256'(o_Itlb_free), 256'(1));
    i_Itlb_drive = 1'b1;
    i_Itlb_PA_34 = pa;
    @(negedge clk);
    i_Itlb_drive = 1'b0;
    i_Itlb_PA_34 = 34'({$urandom, $urandom});
    check({name, ".lookup_busy"}, 256'(o_Itlb_free), 256'(0));
    check({name, ".lookup_noifu"}, 256'(o_driveNext_ifu), 256'(0));
    @(negedge clk);
    if (exp_hit) begin
      check({name, ".hit_drive_ifu"}, 256'(o_driveNext_ifu), 256'(1));
      check({name, ".hit_no_l2"},     256'(o_driveNext_L2Cache), 256'(0));
      check({name, ".hit_data"},      o_hit_data_to_ifu_32B, exp_data);
    end else begin
      check({name, ".miss_drive_l2"}, 256'(o_driveNext_L2Cache), 256'(1));
      check({name, ".miss_addr"},     256'(o_miss_Addr_to_L2cache_34), 256'({pa[33:5], 5'b0}));
      check({name, ".miss_no_ifu"},   256'(o_driveNext_ifu), 256'(0));
      d = $urandom_range(0, 2);
      repeat (d) @(negedge clk);
      i_freeNext_L2Cache = 1'b1;
      @(negedge clk);
      i_freeNext_L2Cache = 1'b0;
      check({name, ".wait_l2_free"},   256'(o_L2Cache_free), 256'(1));
      check({name, ".l2_pulse_once"},  256'(o_driveNext_L2Cache), 256'(0));
      d = $urandom_range(0, 2);
      repeat (d) @(negedge clk);
      i_L2Cache_drive          = 1'b1;
      i_L2Cache_refillLine_32B = refill;
      @(negedge clk);
      i_L2Cache_drive          = 1'b0;
      i_L2Cache_refillLine_32B = rand256();
      check({name, ".refill_drive_ifu"}, 256'(o_driveNext_ifu), 256'(1));
      check({name, ".refill_data"},      o_hit_data_to_ifu_32B, exp_data);
      check({name, ".refill_l2_free"},   256'(o_L2Cache_free), 256'(0));
    end
    @(negedge clk);
    check({name, ".ifu_pulse_once"}, 256'(o_driveNext_ifu), 256'(0));
    check({name, ".data_held"},      o_hit_data_to_ifu_32B, exp_data);
    d = $urandom_range(0, 2);
    repeat (d) @(negedge clk);
    i_freeNext_ifu = 1'b1;
    @(negedge clk);
    i_freeNext_ifu = 1'b0;
    check({name, ".back_idle"}, 256'(o_Itlb_free), 256'(1));
  endtask

  typedef struct {
    string        name;
    logic [33:0]  pa;
    logic [255:0] refill;
    logic         exp_hit;
    logic [255:0] exp_data;
  } vec_t;

  localparam logic [33:0]  PA_A   = 34'h234567_abc;
  localparam logic [33:0]  PA_B   = 34'h256789_abc;
  localparam logic [33:0]  PA_C   = 34'h1abcde_abc;
  localparam logic [255:0] LINE_A = 256'hfea5bf5c4ee8c293_ead6fe726109b4f8_6d1c1c1b60d277f3_8f227c1d5e91b527;
  localparam logic [255:0] LINE_B = 256'h1c7e7580_0d3abd0c_c0a08d74_0dc16ff0_c1d55647_421fdea6_47b6810a_637f1a83;
  localparam logic [255:0] LINE_C = 256'hc0ffee00_11112222_33334444_55556666_77778888_9999aaaa_bbbbcccc_ddddeeee;
  localparam logic [255:0] LINE_D = 256'h0123456789abcdef_fedcba9876543210_a5a5a5a55a5a5a5a_0f0f0f0ff0f0f0f0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t         vecs [7];
    logic         mh;
    logic [255:0] md;
    logic [33:0]  pa;
    logic [21:0]  tag_pool [4];
    logic [6:0]   idx_pool [3];

    // Set 0x55: A, B fill both ways; A hit makes B LRU; C evicts B; B then evicts A.
    vecs[0] = '{"a_miss",  PA_A, LINE_A, 1'b0, LINE_A};
    vecs[1] = '{"b_miss",  PA_B, LINE_B, 1'b0, LINE_B};
    vecs[2] = '{"a_hit",   PA_A, rand256(), 1'b1, LINE_A};
    vecs[3] = '{"c_miss",  PA_C, LINE_C, 1'b0, LINE_C};
    vecs[4] = '{"b_again", PA_B, LINE_D, 1'b0, LINE_D};
    vecs[5] = '{"c_hit",   PA_C, rand256(), 1'b1, LINE_C};
    vecs[6] = '{"a_evict", PA_A, LINE_A, 1'b0, LINE_A};

    @(negedge clk);
    do_reset("reset0");

    for (int i = 0; i < 7; i++) begin
      model_access(vecs[i].pa, vecs[i].refill, mh, md);
      run_req(vecs[i].name, vecs[i].pa, vecs[i].refill, vecs[i].exp_hit, vecs[i].exp_data);
    end

    // Stray strobes in IDLE must be ignored.
    i_L2Cache_drive    = 1'b1;
    i_freeNext_L2Cache = 1'b1;
    i_freeNext_ifu     = 1'b1;
    @(negedge clk);
    i_L2Cache_drive    = 1'b0;
    i_freeNext_L2Cache = 1'b0;
    i_freeNext_ifu     = 1'b0;
    @(negedge clk);
    check("stray.itlb_free", 256'(o_Itlb_free), 256'(1));
    check("stray.l2_free",   256'(o_L2Cache_free), 256'(0));
    check("stray.drive_ifu", 256'(o_driveNext_ifu), 256'(0));

    // Request during WAIT_REFILL ignored, then reset aborts the refill.
    do_reset("reset1");
    i_Itlb_drive = 1'b1;
    i_Itlb_PA_34 = PA_A;
    @(negedge clk);
    i_Itlb_drive = 1'b0;
    @(negedge clk);
    check("abort.miss", 256'(o_driveNext_L2Cache), 256'(1));
    i_freeNext_L2Cache = 1'b1;
    @(negedge clk);
    i_freeNext_L2Cache = 1'b0;
    check("abort.l2_free", 256'(o_L2Cache_free), 256'(1));
    i_Itlb_drive = 1'b1;
    i_Itlb_PA_34 = PA_B;
    @(negedge clk);
    i_Itlb_drive = 1'b0;
    check("abort.ignored_busy", 256'(o_Itlb_free), 256'(0));
    check("abort.still_wait",   256'(o_L2Cache_free), 256'(1));
    @(negedge clk);
    check("abort.no_new_l2",    256'(o_driveNext_L2Cache), 256'(0));
    check("abort.no_ifu",       256'(o_driveNext_ifu), 256'(0));
    do_reset("reset_mid");
    model_access(PA_A, LINE_B, mh, md);
    run_req("after_abort", PA_A, LINE_B, 1'b0, LINE_B);

    // A request coinciding with the IFU release is not accepted.
    model_access(PA_A, LINE_C, mh, md);
    i_Itlb_drive = 1'b1;
    i_Itlb_PA_34 = PA_A;
    @(negedge clk);
    i_Itlb_drive = 1'b0;
    @(negedge clk);
    check("same_cycle.hit",      256'(o_driveNext_ifu), 256'(1));
    check("same_cycle.hit_data", o_hit_data_to_ifu_32B, LINE_B);
    i_freeNext_ifu = 1'b1;
    i_Itlb_drive   = 1'b1;
    i_Itlb_PA_34   = PA_B;
    @(negedge clk);
    i_freeNext_ifu = 1'b0;
    i_Itlb_drive   = 1'b0;
    check("same_cycle.idle", 256'(o_Itlb_free), 256'(1));
    @(negedge clk);
    check("same_cycle.not_taken", 256'(o_Itlb_free), 256'(1));
    check("same_cycle.no_l2",     256'(o_driveNext_L2Cache), 256'(0));
    check("same_cycle.no_ifu",    256'(o_driveNext_ifu), 256'(0));

    // Randomized traffic over a few conflicting sets.
    tag_pool = '{22'h234567, 22'h256789, 22'h1abcde, 22'h3fffff};
    idx_pool = '{7'h55, 7'h00, 7'h7f};
    for (int n = 0; n < 60; n++) begin
      logic [255:0] line;
      pa   = {tag_pool[$urandom_range(0, 3)], idx_pool[$urandom_range(0, 2)], 5'($urandom)};
      line = rand256();
      model_access(pa, line, mh, md);
      run_req($sformatf("rand%0d", n), pa, line, mh, md);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
